sel_base_ctrl: RTL and testbench

//   Sequencer in front of the base-selection display path. Accepts an 8-bit ALU

---
 rtl/sel_base_ctrl_if.sv | 19 +
 rtl/sel_base_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sel_base_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sel_base_ctrl_if.sv
// Result handshake between the ALU result source and the base-selection sequencer.
// The master drives res_valid/res_in, and the slave answers with res_ready.
interface sel_base_ctrl_if;
  logic       res_valid;
  logic [7:0] res_in;
  logic       res_ready;

  modport master (
    output res_valid,
    output res_in,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_in,
    output res_ready
  );
endinterface

// File: rtl/sel_base_ctrl.sv
// Base-selection sequencer: serial 8-bit -> 3-digit BCD conversion with stable held outputs,
// plus the debounced base button (dec -> hex -> oct) and blanking of the display select.
module sel_base_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sel_base_ctrl_if.slave       res_bus,
  input  logic                 btn_base_n,
  input  logic                 blank,
  output logic [1:0]           base_sel,
  output logic [7:0]           r_out,
  output logic [3:0]           bcd_c,
  output logic [3:0]           bcd_d,
  output logic [3:0]           bcd_u,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  localparam int          CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------- conversion
  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_last;
  logic [19:0] r_shift;
  logic [19:0] w_adj;
  logic [19:0] w_shifted;
  logic [2:0]  r_cnt;
  logic [7:0]  r_res_cap;
  logic [7:0]  r_result;
  logic [3:0]  r_bcd_c;
  logic [3:0]  r_bcd_d;
  logic [3:0]  r_bcd_u;
  logic        r_done;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Gating with rst_n keeps ready low for the whole reset, not just after the first edge.
  assign res_bus.res_ready = rst_n & (r_state == S_IDLE);
  assign w_accept          = res_bus.res_valid & res_bus.res_ready;

  assign w_adj     = {add3(r_shift[19:16]), add3(r_shift[15:12]), add3(r_shift[11:8]), r_shift[7:0]};
  assign w_shifted = w_adj << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_CONV;
      end
      S_CONV: begin
        if (r_cnt == 3'd7) begin
          w_state_nxt = S_IDLE;
          w_last      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_res_cap <= '0;
      r_result  <= '0;
      r_bcd_c   <= '0;
      r_bcd_d   <= '0;
      r_bcd_u   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_shift   <= {12'b0, res_bus.res_in};
          r_res_cap <= res_bus.res_in;
          r_cnt     <= '0;
        end
      end else begin
        r_shift <= w_shifted;
        r_cnt   <= r_cnt + 3'd1;
        // Visible outputs only move on the final iteration, so decoders never see partial digits.
        if (w_last) begin
          r_result <= r_res_cap;
          r_bcd_c  <= w_shifted[19:16];
          r_bcd_d  <= w_shifted[15:12];
          r_bcd_u  <= w_shifted[11:8];
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign busy  = (r_state == S_CONV);
  assign done  = r_done;
  assign r_out = r_result;
  assign bcd_c = r_bcd_c;
  assign bcd_d = r_bcd_d;
  assign bcd_u = r_bcd_u;

  // ---------------------------------------------------------------- base button
  logic          r_sync1;
  logic          r_sync2;
  logic          r_btn_acc;
  logic [CW-1:0] r_db_cnt;
  logic          w_db_flip;
  logic          w_press;
  logic [1:0]    r_base;
  logic [1:0]    r_base_sel;

  assign w_db_flip = (r_sync2 != r_btn_acc) && (r_db_cnt == DB_LAST);
  // Only the 1 -> 0 transition of the accepted level counts as a press.
  assign w_press   = w_db_flip && r_btn_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_btn_acc <= 1'b1;
      r_db_cnt  <= '0;
    end else begin
      r_sync1 <= btn_base_n;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_btn_acc) begin
        r_db_cnt <= '0;
      end else if (w_db_flip) begin
        r_btn_acc <= r_sync2;
        r_db_cnt  <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= 2'b00;
      r_base_sel <= 2'b00;
    end else begin
      if (w_press) begin
        r_base <= (r_base == 2'b10) ? 2'b00 : r_base + 2'b01;
      end
      r_base_sel <= blank ? 2'b11 : r_base;
    end
  end

  assign base_sel = r_base_sel;

endmodule

// File: tb/tb_sel_base_ctrl.sv
// Directed bench for sel_base_ctrl: table of conversions plus hand-written button,
// blanking and mid-conversion reset sequences.
module tb_sel_base_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_base_n;
  logic       blank;
  logic [1:0] base_sel;
  logic [7:0] r_out;
  logic [3:0] bcd_c;
  logic [3:0] bcd_d;
  logic [3:0] bcd_u;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] exp_r;
  logic [1:0] exp_base;

  sel_base_ctrl_if bus ();

  sel_base_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_bus    (bus),
    .btn_base_n (btn_base_n),
    .blank      (blank),
    .base_sel   (base_sel),
    .r_out      (r_out),
    .bcd_c      (bcd_c),
    .bcd_d      (bcd_d),
    .bcd_u      (bcd_u),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] value;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
    bit         hold;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Starts at a negedge; ends at the negedge where done is expected high.
  task automatic do_conv(input logic [7:0] v, input logic [3:0] ec, input logic [3:0] ed,
                         input logic [3:0] eu, input bit hold, input bit swap_mid,
                         output int waited);
    waited = 0;
    while (!bus.res_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_accept", 32'(bus.res_ready), 32'd1);
    bus.res_in    = v;
    bus.res_valid = 1'b1;
    @(posedge clk);
    #1;
    check("ready_low_after_accept", 32'(bus.res_ready), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    if (!hold) bus.res_valid = 1'b0;
    if (swap_mid) begin
      bus.res_in    = 8'd7;
      bus.res_valid = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("busy_during_conv", 32'(busy), 32'd1);
      check("done_low_during_conv", 32'(done), 32'd0);
      check("r_out_stable_during_conv", 32'(r_out), 32'(exp_r));
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("ready_after_done", 32'(bus.res_ready), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("r_out", 32'(r_out), 32'(v));
    check("bcd_c", 32'(bcd_c), 32'(ec));
    check("bcd_d", 32'(bcd_d), 32'(ed));
    check("bcd_u", 32'(bcd_u), 32'(eu));
    exp_r = v;
  endtask

  task automatic press(input int low_cycles, input int high_cycles);
    btn_base_n = 1'b0;
    repeat (low_cycles) @(negedge clk);
    btn_base_n = 1'b1;
    repeat (high_cycles) @(negedge clk);
  endtask

  function automatic logic [1:0] next_base(input logic [1:0] b);
    return (b == 2'b10) ? 2'b00 : b + 2'b01;
  endfunction

  initial begin
    int waited;

    vecs[0] = '{value: 8'd255, c: 4'd2, d: 4'd5, u: 4'd5, hold: 1'b0};
    vecs[1] = '{value: 8'd0,   c: 4'd0, d: 4'd0, u: 4'd0, hold: 1'b1};
    vecs[2] = '{value: 8'd100, c: 4'd1, d: 4'd0, u: 4'd0, hold: 1'b1};
    vecs[3] = '{value: 8'd99,  c: 4'd0, d: 4'd9, u: 4'd9, hold: 1'b0};

    rst_n         = 1'b0;
    btn_base_n    = 1'b1;
    blank         = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_in    = 8'd0;
    exp_r         = 8'd0;
    exp_base      = 2'b00;

    #12;
    check("reset_ready", 32'(bus.res_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_r_out", 32'(r_out), 32'd0);
    check("reset_bcd", 32'({bcd_c, bcd_d, bcd_u}), 32'd0);
    check("reset_base_sel", 32'(base_sel), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 32'(bus.res_ready), 32'd1);
    @(negedge clk);

    // Single conversion, then back-to-back accepts with valid held high.
    for (int i = 0; i < 4; i++) begin
      do_conv(vecs[i].value, vecs[i].c, vecs[i].d, vecs[i].u, vecs[i].hold, 1'b0, waited);
      if (i > 1) check("back_to_back_no_wait", 32'(waited), 32'd0);
    end

    // res_in changes to 7 while busy: ignored until the next accept.
    do_conv(8'd50, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, waited);
    do_conv(8'd7, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, waited);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    // Debounce: short glitches rejected, clean presses advance, long hold advances once.
    press(3, 10);
    press(3, 10);
    check("glitch_no_advance", 32'(base_sel), 32'(exp_base));
    for (int p = 0; p < 3; p++) begin
      press(6, 10);
      exp_base = next_base(exp_base);
      check("press_advance", 32'(base_sel), 32'(exp_base));
    end
    check("press_wraps_to_dec", 32'(base_sel), 32'd0);
    btn_base_n = 1'b0;
    repeat (50) @(negedge clk);
    exp_base = next_base(exp_base);
    check("hold_mid", 32'(base_sel), 32'(exp_base));
    repeat (50) @(negedge clk);
    btn_base_n = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_single_advance", 32'(base_sel), 32'(exp_base));

    // Blanking: press while blanked still advances the hidden base.
    blank = 1'b1;
    @(negedge clk);
    check("blank_off_code", 32'(base_sel), 32'd3);
    press(6, 10);
    exp_base = next_base(exp_base);
    check("blank_holds_off", 32'(base_sel), 32'd3);
    blank = 1'b0;
    @(negedge clk);
    check("unblank_shows_new_base", 32'(base_sel), 32'(exp_base));

    // Reset during the 4th conversion cycle aborts without a done pulse.
    bus.res_in    = 8'd200;
    bus.res_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_r    = 8'd0;
    exp_base = 2'b00;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_r_out", 32'(r_out), 32'(exp_r));
    check("abort_bcd", 32'({bcd_c, bcd_d, bcd_u}), 32'd0);
    check("abort_ready", 32'(bus.res_ready), 32'd0);
    check("abort_base_sel", 32'(base_sel), 32'(exp_base));
    repeat (3) begin
      @(negedge clk);
      check("no_done_in_reset", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("ready_after_abort_release", 32'(bus.res_ready), 32'd1);
    do_conv(8'd42, 4'd0, 4'd4, 4'd2, 1'b0, 1'b0, waited);
    check("post_abort_no_wait", 32'(waited), 32'd0);
    @(negedge clk);
    check("post_abort_done_low", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
